j1_uart_io: RTL and testbench

//  J1 I/O-space peripheral: 8N1 UART with TX and RX FIFOs, runtime baud divisor, LED register.

---
 rtl/j1_uart_io_pkg.sv | 39 +++
 rtl/j1_uart_io_sync_fifo.sv | 60 ++++++
 rtl/j1_uart_io.sv | 316 +++++++++++++++++++++++++++++++
 tb/tb_j1_uart_io.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/j1_uart_io_pkg.sv
// rtl/j1_uart_io_pkg.sv - shared address map, status bit indices and FSM state types
package j1_uart_io_pkg;

  // I/O addresses seen by firmware; each uses one select bit of mem_addr[15:12]
  localparam logic [15:0] IO_UART_DATA = 16'h1000;
  localparam logic [15:0] IO_UART_STAT = 16'h2000;
  localparam logic [15:0] IO_LEDS      = 16'h4000;
  localparam logic [15:0] IO_UART_DIV  = 16'h8000;

  // Select bit positions within mem_addr
  localparam int SEL_DATA = 12;
  localparam int SEL_STAT = 13;
  localparam int SEL_LEDS = 14;
  localparam int SEL_DIV  = 15;

  // STATUS register bit indices
  localparam int ST_TX_READY  = 0;
  localparam int ST_RX_AVAIL  = 1;
  localparam int ST_TX_OVF    = 2;
  localparam int ST_RX_OVF    = 3;
  localparam int ST_FRAME_ERR = 4;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

  // RX_WAIT_HIGH holds off new frames after a framing error until the line idles
  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_e;

endpackage

// File: rtl/j1_uart_io_sync_fifo.sv
// rtl/j1_uart_io_sync_fifo.sv - single-clock FIFO with first-word-fall-through head
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             resetq,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

  // A full FIFO still accepts a push when the same cycle frees a slot
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Pointer and occupancy next state; pointers wrap because DEPTH is a power of 2
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/j1_uart_io.sv
// rtl/j1_uart_io.sv - J1 I/O-space UART with TX/RX FIFOs, baud divisor and LED register
module j1_uart_io
  import j1_uart_io_pkg::*;
#(
  parameter int CLKFREQ    = 12000000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 16,
  parameter int LEDS       = 5,
  parameter int DIV_W      = 16
) (
  input  logic            clk,
  input  logic            resetq,
  input  logic            io_rd,
  input  logic            io_wr,
  input  logic [15:0]     mem_addr,
  input  logic [15:0]     dout,
  output logic [15:0]     io_din,
  input  logic            rx,
  output logic            tx,
  output logic [LEDS-1:0] leds
);

  localparam logic [DIV_W-1:0] RESET_DIV = DIV_W'(CLKFREQ / BAUD);
  localparam logic [DIV_W-1:0] MIN_DIV   = DIV_W'(2);
  localparam logic [DIV_W-1:0] ONE       = DIV_W'(1);

  logic sel_data, sel_stat, sel_leds, sel_div;
  logic unused_addr;

  assign sel_data    = mem_addr[SEL_DATA];
  assign sel_stat    = mem_addr[SEL_STAT];
  assign sel_leds    = mem_addr[SEL_LEDS];
  assign sel_div     = mem_addr[SEL_DIV];
  assign unused_addr = ^mem_addr[11:0];

  logic [LEDS-1:0]  leds_q, leds_d;
  logic [DIV_W-1:0] div_q, div_d, div_eff;
  logic             tx_ovf_q, tx_ovf_d, rx_ovf_q, rx_ovf_d, frame_err_q, frame_err_d;
  logic             tx_ovf_set, rx_ovf_set, frame_err_set;

  logic       tx_push, tx_pop, tx_full, tx_empty;
  logic [7:0] tx_head;
  logic       rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0] rx_head;

  // Divisors below 2 would leave no room for the RX half-bit wait
  assign div_eff = (div_q < MIN_DIV) ? MIN_DIV : div_q;

  assign tx_push    = io_wr & sel_data;
  assign rx_pop     = io_rd & sel_data & ~rx_empty;
  assign tx_ovf_set = tx_push & tx_full & ~tx_pop;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .resetq(resetq),
    .push  (tx_push),
    .pop   (tx_pop),
    .din   (dout[7:0]),
    .head  (tx_head),
    .full  (tx_full),
    .empty (tx_empty)
  );

  // ------------------------------------------------------------------ TX
  tx_state_e        tx_state_q, tx_state_d;
  logic [7:0]       tx_shift_q, tx_shift_d;
  logic [DIV_W-1:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
  logic [2:0]       tx_bit_q, tx_bit_d;
  logic             tx_q, tx_d;

  assign tx = tx_q;

  // TX sequencing; a new frame is loaded from IDLE or straight out of STOP
  always_comb begin
    tx_state_d = tx_state_q;
    tx_shift_d = tx_shift_q;
    tx_cnt_d   = tx_cnt_q;
    tx_div_d   = tx_div_q;
    tx_bit_d   = tx_bit_q;
    tx_d       = tx_q;
    tx_pop     = 1'b0;
    unique case (tx_state_q)
      TX_IDLE: begin
        tx_d = 1'b1;
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_shift_d = tx_head;
          tx_div_d   = div_eff;
          tx_cnt_d   = div_eff - ONE;
          tx_d       = 1'b0;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        if (tx_cnt_q == '0) begin
          tx_d       = tx_shift_q[0];
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          tx_bit_d   = 3'd0;
          tx_cnt_d   = tx_div_q - ONE;
          tx_state_d = TX_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q - ONE;
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == '0) begin
          tx_cnt_d = tx_div_q - ONE;
          if (tx_bit_q == 3'd7) begin
            tx_d       = 1'b1;
            tx_state_d = TX_STOP;
          end else begin
            tx_d       = tx_shift_q[0];
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_bit_d   = tx_bit_q + 3'd1;
          end
        end else begin
          tx_cnt_d = tx_cnt_q - ONE;
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == '0) begin
          if (!tx_empty) begin
            tx_pop     = 1'b1;
            tx_shift_d = tx_head;
            tx_div_d   = div_eff;
            tx_cnt_d   = div_eff - ONE;
            tx_d       = 1'b0;
            tx_state_d = TX_START;
          end else begin
            tx_state_d = TX_IDLE;
          end
        end else begin
          tx_cnt_d = tx_cnt_q - ONE;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // TX state registers; line idles high out of reset
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      tx_state_q <= TX_IDLE;
      tx_shift_q <= '0;
      tx_cnt_q   <= '0;
      tx_div_q   <= RESET_DIV;
      tx_bit_q   <= '0;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_shift_q <= tx_shift_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_div_q   <= tx_div_d;
      tx_bit_q   <= tx_bit_d;
      tx_q       <= tx_d;
    end
  end

  // ------------------------------------------------------------------ RX
  rx_state_e        rx_state_q, rx_state_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic [DIV_W-1:0] rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic             rx_s1_q, rx_s2_q;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .resetq(resetq),
    .push  (rx_push),
    .pop   (rx_pop),
    .din   (rx_shift_q),
    .head  (rx_head),
    .full  (rx_full),
    .empty (rx_empty)
  );

  // RX sequencing; samples land mid-bit after the half-bit start check
  always_comb begin
    rx_state_d    = rx_state_q;
    rx_shift_d    = rx_shift_q;
    rx_cnt_d      = rx_cnt_q;
    rx_div_d      = rx_div_q;
    rx_bit_d      = rx_bit_q;
    rx_push       = 1'b0;
    rx_ovf_set    = 1'b0;
    frame_err_set = 1'b0;
    unique case (rx_state_q)
      RX_IDLE: begin
        if (!rx_s2_q) begin
          rx_div_d   = div_eff;
          rx_cnt_d   = (div_eff >> 1) - ONE;
          rx_state_d = RX_START;
        end
      end
      RX_START: begin
        if (rx_cnt_q == '0) begin
          if (rx_s2_q) begin
            rx_state_d = RX_IDLE;
          end else begin
            rx_bit_d   = 3'd0;
            rx_cnt_d   = rx_div_q - ONE;
            rx_state_d = RX_DATA;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - ONE;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == '0) begin
          rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
          rx_cnt_d   = rx_div_q - ONE;
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q - ONE;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == '0) begin
          if (rx_s2_q) begin
            rx_push    = 1'b1;
            rx_ovf_set = rx_full & ~rx_pop;
            rx_state_d = RX_IDLE;
          end else begin
            frame_err_set = 1'b1;
            rx_state_d    = RX_WAIT_HIGH;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - ONE;
        end
      end
      RX_WAIT_HIGH: begin
        if (rx_s2_q) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // RX state registers and the two-flop synchroniser on the pin
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_shift_q <= '0;
      rx_cnt_q   <= '0;
      rx_div_q   <= RESET_DIV;
      rx_bit_q   <= '0;
    end else begin
      rx_s1_q    <= rx;
      rx_s2_q    <= rx_s1_q;
      rx_state_q <= rx_state_d;
      rx_shift_q <= rx_shift_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_div_q   <= rx_div_d;
      rx_bit_q   <= rx_bit_d;
    end
  end

  // ------------------------------------------------------------ registers
  // Register writes and sticky flags; a set in the same cycle beats a clear
  always_comb begin
    leds_d      = leds_q;
    div_d       = div_q;
    tx_ovf_d    = tx_ovf_q;
    rx_ovf_d    = rx_ovf_q;
    frame_err_d = frame_err_q;
    if (io_wr && sel_leds) leds_d = dout[LEDS-1:0];
    if (io_wr && sel_div)  div_d  = dout[DIV_W-1:0];
    if (io_wr && sel_stat) begin
      if (dout[ST_TX_OVF])    tx_ovf_d    = 1'b0;
      if (dout[ST_RX_OVF])    rx_ovf_d    = 1'b0;
      if (dout[ST_FRAME_ERR]) frame_err_d = 1'b0;
    end
    if (tx_ovf_set)    tx_ovf_d    = 1'b1;
    if (rx_ovf_set)    rx_ovf_d    = 1'b1;
    if (frame_err_set) frame_err_d = 1'b1;
  end

  // Register file flops
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      leds_q      <= '0;
      div_q       <= RESET_DIV;
      tx_ovf_q    <= 1'b0;
      rx_ovf_q    <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      leds_q      <= leds_d;
      div_q       <= div_d;
      tx_ovf_q    <= tx_ovf_d;
      rx_ovf_q    <= rx_ovf_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign leds = leds_q;

  logic [15:0] rd_leds, rd_div, rd_stat, rd_data;

  // Read mux: OR of every selected source so multi-select reads combine
  always_comb begin
    rd_leds = '0;
    rd_leds[LEDS-1:0] = leds_q;
    rd_div  = '0;
    rd_div[DIV_W-1:0] = div_q;
    rd_stat = {11'b0, frame_err_q, rx_ovf_q, tx_ovf_q, ~rx_empty, ~tx_full};
    rd_data = {8'h00, (rx_empty ? 8'h00 : rx_head)};
    io_din  = '0;
    if (sel_data) io_din = io_din | rd_data;
    if (sel_stat) io_din = io_din | rd_stat;
    if (sel_leds) io_din = io_din | rd_leds;
    if (sel_div)  io_din = io_din | rd_div;
  end

endmodule

// File: tb/tb_j1_uart_io.sv
// tb/tb_j1_uart_io.sv - scoreboard bench for the j1_uart_io peripheral
module tb_j1_uart_io;
  import j1_uart_io_pkg::*;

  localparam int LEDS      = 5;
  localparam int RESET_DIV = 12000000 / 9600;

  logic            clk = 1'b0;
  logic            resetq = 1'b0;
  logic            io_rd = 1'b0;
  logic            io_wr = 1'b0;
  logic [15:0]     mem_addr = 16'h0;
  logic [15:0]     dout = 16'h0;
  logic [15:0]     io_din;
  logic            rx = 1'b1;
  logic            tx;
  logic [LEDS-1:0] leds;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [7:0] exp_q[$];

  j1_uart_io #(
    .CLKFREQ(12000000), .BAUD(9600), .FIFO_DEPTH(16), .LEDS(LEDS), .DIV_W(16)
  ) dut (
    .clk(clk), .resetq(resetq), .io_rd(io_rd), .io_wr(io_wr),
    .mem_addr(mem_addr), .dout(dout), .io_din(io_din),
    .rx(rx), .tx(tx), .leds(leds)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    mem_addr = a; dout = d; io_wr = 1'b1;
    @(negedge clk);
    io_wr = 1'b0; mem_addr = 16'h0; dout = 16'h0;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [15:0] d);
    @(negedge clk);
    mem_addr = a; io_rd = 1'b1;
    #1 d = io_din;
    @(negedge clk);
    io_rd = 1'b0; mem_addr = 16'h0;
  endtask

  task automatic peek(input logic [15:0] a, output logic [15:0] d);
    @(negedge clk);
    mem_addr = a;
    #1 d = io_din;
    mem_addr = 16'h0;
  endtask

  task automatic drive_rx(input logic [7:0] b, input logic stop, input int div);
    @(negedge clk);
    rx = 1'b0;
    repeat (div) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (div) @(negedge clk);
    end
    rx = stop;
    repeat (div) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic decode_tx(input int div, output logic [7:0] b, output int wait_n, output logic ok);
    ok = 1'b1; wait_n = 0; b = 8'h00;
    do begin
      @(negedge clk);
      wait_n++;
    end while (tx !== 1'b0 && wait_n < 2000);
    if (tx !== 1'b0) begin
      ok = 1'b0;
      return;
    end
    repeat (div / 2) @(negedge clk);
    if (tx !== 1'b0) ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (div) @(negedge clk);
      b[i] = tx;
    end
    repeat (div) @(negedge clk);
    if (tx !== 1'b1) ok = 1'b0;
  endtask

  task automatic test_reset;
    logic [15:0] d;
    peek(IO_UART_STAT, d);
    total_cnt++;
    if (d !== 16'h0001) $display("FAIL reset_status: got %h expected %h", d, 16'h0001); else pass_cnt++;
    peek(IO_UART_DIV, d);
    total_cnt++;
    if (d !== 16'(RESET_DIV)) $display("FAIL reset_div: got %h expected %h", d, 16'(RESET_DIV)); else pass_cnt++;
    total_cnt++;
    if (tx !== 1'b1 || leds !== '0) $display("FAIL reset_pins: got tx=%b leds=%h expected tx=1 leds=0", tx, leds); else pass_cnt++;
  endtask

  task automatic test_regs;
    logic [15:0] d;
    bus_write(IO_LEDS, 16'hFFF5);
    total_cnt++;
    if (leds !== 5'h15) $display("FAIL leds_write: got %h expected %h", leds, 5'h15); else pass_cnt++;
    bus_write(16'h0800, 16'h0000);
    peek(IO_LEDS, d);
    total_cnt++;
    if (d !== 16'h0015) $display("FAIL leds_read_after_stray_write: got %h expected %h", d, 16'h0015); else pass_cnt++;
    peek(16'h0001, d);
    total_cnt++;
    if (d !== 16'h0000) $display("FAIL unmapped_read: got %h expected %h", d, 16'h0000); else pass_cnt++;
    peek(IO_LEDS | IO_UART_DIV, d);
    total_cnt++;
    if (d !== (16'h0015 | 16'(RESET_DIV))) $display("FAIL multi_select_read: got %h expected %h", d, 16'h0015 | 16'(RESET_DIV)); else pass_cnt++;
  endtask

  task automatic test_tx_frame;
    logic [15:0] d;
    logic [7:0]  b;
    logic        e;
    int          errs;
    bus_write(IO_UART_DIV, 16'd4);
    peek(IO_UART_DIV, d);
    total_cnt++;
    if (d !== 16'd4) $display("FAIL div_readback: got %h expected %h", d, 16'd4); else pass_cnt++;
    b = 8'hA5;
    errs = 0;
    bus_write(IO_UART_DATA, {8'h00, b});
    for (int i = 0; i <= 40; i++) begin
      @(negedge clk);
      if (i < 4)        e = 1'b0;
      else if (i < 36)  e = b[(i - 4) / 4];
      else              e = 1'b1;
      if (tx !== e) errs++;
    end
    total_cnt++;
    if (errs != 0) $display("FAIL tx_waveform_A5: got %0d wrong samples expected 0", errs); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    logic [7:0] bytes [3];
    bytes[0] = 8'h81; bytes[1] = 8'h5A; bytes[2] = 8'($urandom_range(0, 255));
    for (int k = 0; k < 3; k++) exp_q.push_back(bytes[k]);
    fork
      begin
        for (int k = 0; k < 3; k++) bus_write(IO_UART_DATA, {8'h00, bytes[k]});
      end
      begin
        logic [7:0] got, want;
        int         n;
        logic       ok;
        for (int k = 0; k < 3; k++) begin
          decode_tx(4, got, n, ok);
          want = exp_q.pop_front();
          total_cnt++;
          if (!ok || got !== want) $display("FAIL tx_b2b_byte%0d: got %h ok=%b expected %h", k, got, ok, want); else pass_cnt++;
          if (k > 0) begin
            total_cnt++;
            if (n != 2) $display("FAIL tx_b2b_gap%0d: got %0d expected %0d", k, n, 2); else pass_cnt++;
          end
        end
      end
    join
  endtask

  task automatic test_tx_full_and_async_reset;
    logic [15:0] d;
    bus_write(IO_UART_DIV, 16'hFFFF);
    for (int i = 0; i < 16; i++) bus_write(IO_UART_DATA, 16'(i));
    peek(IO_UART_STAT, d);
    total_cnt++;
    if (d !== 16'h0001) $display("FAIL tx_16_written: got %h expected %h", d, 16'h0001); else pass_cnt++;
    bus_write(IO_UART_DATA, 16'h0010);
    peek(IO_UART_STAT, d);
    total_cnt++;
    if (d !== 16'h0000) $display("FAIL tx_full: got %h expected %h", d, 16'h0000); else pass_cnt++;
    bus_write(IO_UART_DATA, 16'h0011);
    peek(IO_UART_STAT, d);
    total_cnt++;
    if (d !== 16'h0004) $display("FAIL tx_ovf_set: got %h expected %h", d, 16'h0004); else pass_cnt++;
    bus_write(IO_UART_STAT, 16'h0004);
    peek(IO_UART_STAT, d);
    total_cnt++;
    if (d !== 16'h0000) $display("FAIL tx_ovf_w1c: got %h expected %h", d, 16'h0000); else pass_cnt++;
    bus_write(IO_UART_STAT | IO_UART_DATA, 16'h0004);
    peek(IO_UART_STAT, d);
    total_cnt++;
    if (d !== 16'h0004) $display("FAIL set_beats_clear: got %h expected %h", d, 16'h0004); else pass_cnt++;
    total_cnt++;
    if (tx !== 1'b0) $display("FAIL tx_start_bit_held: got %b expected 0", tx); else pass_cnt++;
    @(negedge clk);
    #2 resetq = 1'b0;
    #1;
    total_cnt++;
    if (tx !== 1'b1) $display("FAIL async_reset_tx: got %b expected 1", tx); else pass_cnt++;
    repeat (3) @(negedge clk);
    resetq = 1'b1;
    test_reset();
  endtask

  task automatic test_rx_single;
    logic [15:0] d, want;
    bus_write(IO_UART_DIV, 16'd8);
    exp_q.push_back(8'h3C);
    drive_rx(8'h3C, 1'b1, 8);
    repeat (2) @(negedge clk);
    peek(IO_UART_STAT, d);
    total_cnt++;
    if (d !== 16'h0003) $display("FAIL rx_avail: got %h expected %h", d, 16'h0003); else pass_cnt++;
    bus_read(IO_UART_DATA, d);
    want = {8'h00, exp_q.pop_front()};
    total_cnt++;
    if (d !== want) $display("FAIL rx_data: got %h expected %h", d, want); else pass_cnt++;
    peek(IO_UART_STAT, d);
    total_cnt++;
    if (d !== 16'h0001) $display("FAIL rx_drained: got %h expected %h", d, 16'h0001); else pass_cnt++;
    bus_read(IO_UART_DATA, d);
    total_cnt++;
    if (d !== 16'h0000) $display("FAIL rx_empty_read: got %h expected %h", d, 16'h0000); else pass_cnt++;
  endtask

  task automatic test_rx_overflow;
    logic [15:0] d, want;
    logic [7:0]  b;
    int          errs;
    for (int i = 0; i < 17; i++) begin
      b = 8'($urandom_range(0, 255));
      if (i < 16) exp_q.push_back(b);
      drive_rx(b, 1'b1, 8);
    end
    repeat (2) @(negedge clk);
    peek(IO_UART_STAT, d);
    total_cnt++;
    if (d !== 16'h000B) $display("FAIL rx_ovf_set: got %h expected %h", d, 16'h000B); else pass_cnt++;
    errs = 0;
    for (int i = 0; i < 16; i++) begin
      bus_read(IO_UART_DATA, d);
      want = {8'h00, exp_q.pop_front()};
      if (d !== want) begin
        errs++;
        $display("FAIL rx_ovf_order%0d: got %h expected %h", i, d, want);
      end
    end
    total_cnt++;
    if (errs == 0) pass_cnt++;
    bus_write(IO_UART_STAT, 16'h0008);
    peek(IO_UART_STAT, d);
    total_cnt++;
    if (d !== 16'h0001) $display("FAIL rx_ovf_w1c: got %h expected %h", d, 16'h0001); else pass_cnt++;
  endtask

  task automatic test_frame_err_and_glitch;
    logic [15:0] d, want;
    drive_rx(8'h55, 1'b0, 8);
    repeat (4) @(negedge clk);
    peek(IO_UART_STAT, d);
    total_cnt++;
    if (d !== 16'h0011) $display("FAIL frame_err: got %h expected %h", d, 16'h0011); else pass_cnt++;
    bus_write(IO_UART_STAT, 16'h0010);
    @(negedge clk);
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    peek(IO_UART_STAT, d);
    total_cnt++;
    if (d !== 16'h0001) $display("FAIL glitch_ignored: got %h expected %h", d, 16'h0001); else pass_cnt++;
    exp_q.push_back(8'hC3);
    drive_rx(8'hC3, 1'b1, 8);
    repeat (2) @(negedge clk);
    bus_read(IO_UART_DATA, d);
    want = {8'h00, exp_q.pop_front()};
    total_cnt++;
    if (d !== want) $display("FAIL rx_after_err: got %h expected %h", d, want); else pass_cnt++;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    resetq = 1'b1;
    test_reset();
    test_regs();
    test_tx_frame();
    test_back_to_back();
    test_tx_full_and_async_reset();
    test_rx_single();
    test_rx_overflow();
    test_frame_err_and_glitch();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
